// File: rtl/cpu_mon_pkg.sv
// Shared definitions for the CPU run monitor.
//   state_t        : monitor FSM states (RUN is the reset state)
//   OP_RTYPE       : R-type opcode field value
//   SYSCALL_FUNCT  : funct field value of a syscall
//   REG_ZERO       : register number of the hard-wired zero register
//   is_syscall()   : decodes a retiring instruction word as a syscall
package cpu_mon_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALTED  = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    localparam logic [5:0] SYSCALL_FUNCT = 6'h0C;
    localparam logic [5:0] OP_RTYPE      = 6'h00;
    localparam logic [4:0] REG_ZERO      = 5'd0;

    // Only opcode and funct matter; the code field of a syscall is free.
    function automatic logic is_syscall(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_RTYPE) && (funct == SYSCALL_FUNCT);
    endfunction

endpackage

// File: rtl/pc_repeat_detector.sv
// Detects a CPU spinning on one PC (jump-to-self halt idiom).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   retire      : an instruction retires this cycle
//   pc          : PC of the retiring instruction
//   freeze      : monitor has left RUN; tracking stops
//   repeatHalt  : combinational, high during the retirement that completes
//                 HALT_REPEAT consecutive retirements at the same PC
module pc_repeat_detector #(
    parameter int WIDTH       = 32,
    parameter int HALT_REPEAT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             retire,
    input  logic [WIDTH-1:0] pc,
    input  logic             freeze,
    output logic             repeatHalt
);
    import cpu_mon_pkg::*;

    localparam int CNT_W = $clog2(HALT_REPEAT + 1);

    logic [WIDTH-1:0] prev_pc_reg;
    logic             prev_valid_reg;
    logic [CNT_W-1:0] rep_cnt_reg;
    logic             pc_match;

    // prev_valid gates the compare so the first retirement after reset can
    // never look like a repeat of the cleared PC register.
    assign pc_match   = prev_valid_reg && (pc == prev_pc_reg);
    assign repeatHalt = retire && !freeze && pc_match &&
                        (rep_cnt_reg == CNT_W'(HALT_REPEAT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pc_reg    <= '0;
            prev_valid_reg <= 1'b0;
            rep_cnt_reg    <= '0;
        end else if (retire && !freeze) begin
            prev_pc_reg    <= pc;
            prev_valid_reg <= 1'b1;
            if (!pc_match)
                rep_cnt_reg <= CNT_W'(1);
            else if (rep_cnt_reg != CNT_W'(HALT_REPEAT))
                rep_cnt_reg <= rep_cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control and observation block for the single-cycle CPU.
// Detects halt (syscall or PC repeat) and cycle-budget timeout, counts
// retirements / cycles / data-memory writes (saturating), records the last
// data-memory write address and watches NWATCH registers.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   retire, pc, instr          : retirement stream from the core
//   regWE, regWAddr, regWData  : register-file write port
//   dmWE, dmAddr               : data-memory write port
//   instrCount, cycleCount,
//   dmWriteCount, lastDmAddr   : counters / last write address
//   watchVal, watchHit         : per-channel last value and sticky hit flag
//   halted, timedOut, done     : run status (sticky until reset)
module cpu_run_monitor #(
    parameter int                    WIDTH       = 32,
    parameter int                    COUNT_W     = 17,
    parameter int                    MAX_CYCLES  = 512,
    parameter int                    HALT_REPEAT = 4,
    parameter int                    NWATCH      = 2,
    parameter logic [NWATCH*5-1:0]   WATCH_REGS  = {5'd3, 5'd2}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    retire,
    input  logic [WIDTH-1:0]        pc,
    input  logic [31:0]             instr,
    input  logic                    regWE,
    input  logic [4:0]              regWAddr,
    input  logic [WIDTH-1:0]        regWData,
    input  logic                    dmWE,
    input  logic [WIDTH-1:0]        dmAddr,
    output logic [COUNT_W-1:0]      instrCount,
    output logic [COUNT_W-1:0]      cycleCount,
    output logic [COUNT_W-1:0]      dmWriteCount,
    output logic [WIDTH-1:0]        lastDmAddr,
    output logic [NWATCH*WIDTH-1:0] watchVal,
    output logic [NWATCH-1:0]       watchHit,
    output logic                    halted,
    output logic                    timedOut,
    output logic                    done
);
    import cpu_mon_pkg::*;

    localparam int NCNT      = 3;
    localparam int CNT_INSTR = 0;
    localparam int CNT_CYCLE = 1;
    localparam int CNT_DMW   = 2;

    state_t state_reg;
    logic   halted_reg;
    logic   timed_out_reg;
    logic   done_reg;
    logic   run;
    logic   repeat_halt;
    logic   halt_evt;
    logic   timeout_evt;
    logic   unused_instr_bits;

    logic [NCNT-1:0]    cnt_inc;
    logic [COUNT_W-1:0] cnt_reg [NCNT];
    logic [WIDTH-1:0]   last_dm_addr_reg;
    logic [WIDTH-1:0]   watch_val_reg [NWATCH];
    logic [NWATCH-1:0]  watch_hit_reg;

    assign run = (state_reg == RUN);
    assign unused_instr_bits = ^instr[25:6];

    pc_repeat_detector #(
        .WIDTH       (WIDTH),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_repeat (
        .clk        (clk),
        .reset      (reset),
        .retire     (retire),
        .pc         (pc),
        .freeze     (!run),
        .repeatHalt (repeat_halt)
    );

    assign halt_evt    = run && retire && (is_syscall(instr[31:26], instr[5:0]) || repeat_halt);
    // The cycle counter reaches MAX_CYCLES on this edge.
    assign timeout_evt = run && (cnt_reg[CNT_CYCLE] == COUNT_W'(MAX_CYCLES - 1));

    // Halt is checked first so a coincident timeout is suppressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= RUN;
            halted_reg    <= 1'b0;
            timed_out_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (halt_evt) begin
                        state_reg  <= HALTED;
                        halted_reg <= 1'b1;
                        done_reg   <= 1'b1;
                    end else if (timeout_evt) begin
                        state_reg     <= TIMEOUT;
                        timed_out_reg <= 1'b1;
                        done_reg      <= 1'b1;
                    end
                end
                default: state_reg <= state_reg;
            endcase
        end
    end

    assign cnt_inc[CNT_INSTR] = retire;
    assign cnt_inc[CNT_CYCLE] = 1'b1;
    assign cnt_inc[CNT_DMW]   = dmWE;

    // Saturating counters, all frozen outside RUN.
    generate
        for (genvar gi = 0; gi < NCNT; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (reset)
                    cnt_reg[gi] <= '0;
                else if (run && cnt_inc[gi] && (cnt_reg[gi] != '1))
                    cnt_reg[gi] <= cnt_reg[gi] + COUNT_W'(1);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)
            last_dm_addr_reg <= '0;
        else if (run && dmWE)
            last_dm_addr_reg <= dmAddr;
    end

    // Each channel compares independently, so duplicate watch entries all update.
    generate
        for (genvar gi = 0; gi < NWATCH; gi++) begin : g_watch
            logic [4:0] watch_reg_num;
            assign watch_reg_num = WATCH_REGS[gi*5 +: 5];

            always_ff @(posedge clk) begin
                if (reset) begin
                    watch_val_reg[gi] <= '0;
                    watch_hit_reg[gi] <= 1'b0;
                end else if (run && regWE && (regWAddr == watch_reg_num) &&
                             (regWAddr != REG_ZERO)) begin
                    watch_val_reg[gi] <= regWData;
                    watch_hit_reg[gi] <= 1'b1;
                end
            end

            assign watchVal[gi*WIDTH +: WIDTH] = watch_val_reg[gi];
        end
    endgenerate

    assign instrCount   = cnt_reg[CNT_INSTR];
    assign cycleCount   = cnt_reg[CNT_CYCLE];
    assign dmWriteCount = cnt_reg[CNT_DMW];
    assign lastDmAddr   = last_dm_addr_reg;
    assign watchHit     = watch_hit_reg;
    assign halted       = halted_reg;
    assign timedOut     = timed_out_reg;
    assign done         = done_reg;

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Synthesisable run-control and observation block that sits beside the single-cycle CPU core in the simulation top level. It replaces the fixed-delay stop and hand-picked register dumps with on-chip halt detection, a cycle-budget timeout, retired-instruction and memory-write counters, and N parametrised register watch channels. Benches wait on `done`, then read counters and watch values directly.

## Interface
Parameters:
- WIDTH, 32, datapath/PC width
- COUNT_W, 17, width of all counters
- MAX_CYCLES, 512, cycle budget before timeout (≥ 2)
- HALT_REPEAT, 4, consecutive retirements at an identical PC that constitute a halt (≥ 2)
- NWATCH, 2, number of register watch channels (≥ 1)
- WATCH_REGS, {5'd3, 5'd2}, packed NWATCH×5-bit register numbers; channel i = bits [5i+4:5i]

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- retire  in  1  CPU retired one instruction this cycle
- pc  in  WIDTH  PC of the retiring instruction
- instr  in  32  retiring instruction word
- regWE  in  1  register-file write enable
- regWAddr  in  5  register-file write address
- regWData  in  WIDTH  register-file write data
- dmWE  in  1  data-memory write enable
- dmAddr  in  WIDTH  data-memory address
- instrCount  out  COUNT_W  retired instructions
- cycleCount  out  COUNT_W  cycles spent in RUN
- dmWriteCount  out  COUNT_W  data-memory writes
- lastDmAddr  out  WIDTH  address of the most recent data-memory write
- watchVal  out  NWATCH*WIDTH  last value written to each watched register
- watchHit  out  NWATCH  sticky: watched register written at least once
- halted  out  1  halt detected
- timedOut  out  1  cycle budget exhausted
- done  out  1  halted | timedOut

## Operation
- FSM states: RUN (reset state), HALTED, TIMEOUT. HALTED and TIMEOUT are terminal; only reset leaves them.
- RUN → HALTED on a retirement that is a syscall (opcode 0, funct 6'h0C), or on the retirement that completes HALT_REPEAT consecutive retirements at the same PC.
- Repeat tracking: `prevPc`/`prevValid` hold the last retired PC; `repCnt` is set to 1 on the first retirement or on a PC change, and incremented on a match. Non-retiring cycles leave tracking unchanged.
- RUN → TIMEOUT on the edge at which cycleCount becomes MAX_CYCLES.
- If a halt and a timeout occur on the same edge, HALTED wins; timedOut stays 0.
- In RUN:
  - cycleCount +1 every cycle.
  - instrCount +1 per retirement, including the halting retirement.
  - dmWriteCount +1 and lastDmAddr ← dmAddr on dmWE.
  - Watch channel i: on regWE with regWAddr == WATCH_REGS[i] and regWAddr ≠ 0, watchVal[i] ← regWData and watchHit[i] ← 1. Writes to $zero are ignored. Multiple channels watching the same register all update.
- All counters saturate at all-ones; they never wrap.
- In HALTED/TIMEOUT, every counter, watch value and address register is frozen and all inputs are ignored.

## Timing
- Reset values: all outputs 0; FSM in RUN; prevValid 0.
- Reset mid-run clears everything on the same edge; the first post-reset retirement never counts as a repeat.
- All outputs are registered, with one-cycle latency from the sampling edge. Example: regWE at edge k makes watchVal visible after edge k.
- halted/timedOut/done rise in the cycle following the deciding edge and hold until reset.
- No handshake; inputs are sampled every edge and are qualified only by retire/regWE/dmWE.

## Structure
- Shared package `cpu_mon_pkg`:
  - state enum {RUN, HALTED, TIMEOUT}
  - SYSCALL_FUNCT = 6'h0C, OP_RTYPE = 6'h00
  - REG_ZERO = 5'd0
- One sub-module: `pc_repeat_detector`, parametrised by WIDTH and HALT_REPEAT. Inputs clk, reset, retire, pc, freeze; output `repeatHalt` (combinational, asserted during the completing retirement).
- Counters and watch channels are generate loops in the top level.

## Test plan
- Jump-to-self: 3 distinct PCs, then PC 0x0C retired 4 times → halted=1 after the 4th; instrCount=7; timedOut=0.
- Syscall: write $v0=0x2A, then retire instr 0x0000000C → halted=1; watchVal[0]=0x2A; watchHit=2'b01; instrCount=2.
- Timeout: MAX_CYCLES=16, PC increments every retirement → timedOut=1 with cycleCount=16; counters frozen for 10 more cycles.
- Simultaneous: 4th repeat retirement lands on the edge where cycleCount reaches MAX_CYCLES → halted=1, timedOut=0.
- Watch/$zero: regWE to r0 with 0xFFFF, then r3=0x5 → watchVal[0] unchanged, watchVal[1]=0x5; 3 dmWE at 0x10/0x14/0x18 → dmWriteCount=3, lastDmAddr=0x18.
- Reset mid-run: assert reset in cycle 5 after 2 repeats → all outputs 0 next cycle; 3 further repeats do not halt (HALT_REPEAT=4).
